reg_scoreboard_ctrl: RTL and testbench

//  Issue/writeback controller for the register cell array. Checks RAW/WAW hazards against
//  the cells' write-reserve bits, reserves the destination on issue, and round-robin

---
 rtl/reg_scoreboard_ctrl_if.sv | 46 ++++
 rtl/reg_scoreboard_ctrl.sv | 173 +++++++++++++++++
 tb/tb_reg_scoreboard_ctrl.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_scoreboard_ctrl_if.sv
// Handshake and cell-array bundle between issue stage, FU writeback ports,
// register cell array and the scoreboard controller.
interface reg_scoreboard_ctrl_if #(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int WORD = 32
);
  logic            iss_valid;
  logic            iss_ready;
  logic [AW-1:0]   iss_rs1;
  logic [AW-1:0]   iss_rs2;
  logic [AW-1:0]   iss_rd;
  logic            iss_rd_we;
  logic            wb0_valid;
  logic            wb0_ready;
  logic [AW-1:0]   wb0_rd;
  logic [WORD-1:0] wb0_data;
  logic            wb1_valid;
  logic            wb1_ready;
  logic [AW-1:0]   wb1_rd;
  logic [WORD-1:0] wb1_data;
  logic [NREG-1:0] rf_reserved;
  logic [NREG-1:0] rf_reserve;
  logic [NREG-1:0] rf_unreserve;
  logic [NREG-1:0] rf_wb;
  logic [WORD-1:0] rf_wdata;
  logic            flush;
  logic            flush_done;
  logic [AW:0]     outstanding;

  modport master (
    output iss_valid, iss_rs1, iss_rs2, iss_rd, iss_rd_we,
    output wb0_valid, wb0_rd, wb0_data, wb1_valid, wb1_rd, wb1_data,
    output rf_reserved, flush,
    input  iss_ready, wb0_ready, wb1_ready,
    input  rf_reserve, rf_unreserve, rf_wb, rf_wdata, flush_done, outstanding
  );

  modport slave (
    input  iss_valid, iss_rs1, iss_rs2, iss_rd, iss_rd_we,
    input  wb0_valid, wb0_rd, wb0_data, wb1_valid, wb1_rd, wb1_data,
    input  rf_reserved, flush,
    output iss_ready, wb0_ready, wb1_ready,
    output rf_reserve, rf_unreserve, rf_wb, rf_wdata, flush_done, outstanding
  );
endinterface

// File: rtl/reg_scoreboard_ctrl.sv
// Issue/writeback scoreboard: RAW/WAW hazard check against cell reserve bits,
// round-robin writeback arbitration, reservation counter and flush drain FSM.
module reg_scoreboard_ctrl #(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int WORD = 32
) (
  input logic                  clk,
  input logic                  rst,
  reg_scoreboard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [AW:0] CNT_MAX = (AW + 1)'(NREG - 1);

  state_t          state_r;
  logic            rr_r;           // 0: wb0 has priority, 1: wb1 has priority
  logic [AW:0]     cnt_r;
  logic            flush_done_r;

  logic            iss_ready_s;
  logic            rsv_fire_s;
  logic [NREG-1:0] reserve_s;
  logic            g0_s;
  logic            g1_s;
  logic [AW-1:0]   grd_s;
  logic [WORD-1:0] gdata_s;
  logic [NREG-1:0] wb_strobe_s;
  logic [WORD-1:0] wdata_s;
  logic            dec_s;

  // Index 0 is the hardwired zero register: it never decodes to a strobe.
  function automatic logic [NREG-1:0] dec_onehot(input logic [AW-1:0] idx);
    logic [NREG-1:0] v;
    v = {NREG{1'b0}};
    if (idx != {AW{1'b0}}) begin
      v[idx] = 1'b1;
    end else begin
      v = {NREG{1'b0}};
    end
    return v;
  endfunction

  function automatic logic is_rsv(input logic [NREG-1:0] rsv, input logic [AW-1:0] idx);
    return (idx != {AW{1'b0}}) && rsv[idx];
  endfunction

  // Issue hazard check and destination reservation strobe.
  always_comb begin
    iss_ready_s = 1'b0;
    rsv_fire_s  = 1'b0;
    reserve_s   = {NREG{1'b0}};
    if (state_r == ST_RUN) begin
      iss_ready_s = ~is_rsv(bus.rf_reserved, bus.iss_rs1)
                  & ~is_rsv(bus.rf_reserved, bus.iss_rs2)
                  & ~(bus.iss_rd_we & is_rsv(bus.rf_reserved, bus.iss_rd));
    end else begin
      iss_ready_s = 1'b0;
    end
    rsv_fire_s = bus.iss_valid & iss_ready_s & bus.iss_rd_we & (bus.iss_rd != {AW{1'b0}});
    if (rsv_fire_s) begin
      reserve_s = dec_onehot(bus.iss_rd);
    end else begin
      reserve_s = {NREG{1'b0}};
    end
  end

  // Writeback arbitration and cell write/unreserve strobes.
  always_comb begin
    g0_s        = bus.wb0_valid & (~bus.wb1_valid | ~rr_r);
    g1_s        = bus.wb1_valid & (~bus.wb0_valid | rr_r);
    grd_s       = {AW{1'b0}};
    gdata_s     = {WORD{1'b0}};
    wb_strobe_s = {NREG{1'b0}};
    wdata_s     = {WORD{1'b0}};
    dec_s       = 1'b0;
    if (g0_s) begin
      grd_s   = bus.wb0_rd;
      gdata_s = bus.wb0_data;
    end else if (g1_s) begin
      grd_s   = bus.wb1_rd;
      gdata_s = bus.wb1_data;
    end else begin
      grd_s   = {AW{1'b0}};
      gdata_s = {WORD{1'b0}};
    end
    if (g0_s | g1_s) begin
      wb_strobe_s = dec_onehot(grd_s);
      wdata_s     = gdata_s;
      dec_s       = is_rsv(bus.rf_reserved, grd_s);
    end else begin
      wb_strobe_s = {NREG{1'b0}};
      wdata_s     = {WORD{1'b0}};
      dec_s       = 1'b0;
    end
  end

  // Round-robin pointer: after any grant the other unit gets priority.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_r <= 1'b0;
    end else if (g0_s | g1_s) begin
      rr_r <= g0_s;
    end else begin
      rr_r <= rr_r;
    end
  end

  // Outstanding reservation counter; a stray writeback does not decrement.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= {(AW + 1){1'b0}};
    end else if (rsv_fire_s && !dec_s) begin
      cnt_r <= (cnt_r == CNT_MAX) ? cnt_r : cnt_r + {{AW{1'b0}}, 1'b1};
    end else if (dec_s && !rsv_fire_s) begin
      cnt_r <= (cnt_r == {(AW + 1){1'b0}}) ? cnt_r : cnt_r - {{AW{1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Flush drain FSM; flush_done is registered and high only while in DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= ST_RUN;
      flush_done_r <= 1'b0;
    end else begin
      case (state_r)
        ST_RUN: begin
          flush_done_r <= 1'b0;
          if (bus.flush) begin
            state_r <= ST_DRAIN;
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_DRAIN: begin
          if (cnt_r == {(AW + 1){1'b0}}) begin
            state_r      <= ST_DONE;
            flush_done_r <= 1'b1;
          end else begin
            state_r      <= ST_DRAIN;
            flush_done_r <= 1'b0;
          end
        end
        ST_DONE: begin
          state_r      <= ST_RUN;
          flush_done_r <= 1'b0;
        end
        default: begin
          state_r      <= ST_RUN;
          flush_done_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.iss_ready    = iss_ready_s;
  assign bus.rf_reserve   = reserve_s;
  assign bus.wb0_ready    = g0_s;
  assign bus.wb1_ready    = g1_s;
  assign bus.rf_wb        = wb_strobe_s;
  assign bus.rf_unreserve = wb_strobe_s;
  assign bus.rf_wdata     = wdata_s;
  assign bus.flush_done   = flush_done_r;
  assign bus.outstanding  = cnt_r;

endmodule

// File: tb/tb_reg_scoreboard_ctrl.sv
// Bench for reg_scoreboard_ctrl: combinational vector table, directed multi-cycle
// sequences, and random traffic checked against a behavioural scoreboard model.
module tb_reg_scoreboard_ctrl;
  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int WORD = 32;
  localparam logic [31:0] D0 = 32'hA5A5_0001;
  localparam logic [31:0] D1 = 32'h3C3C_0002;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  reg_scoreboard_ctrl_if #(.NREG(NREG), .AW(AW), .WORD(WORD)) bus ();
  reg_scoreboard_ctrl #(.NREG(NREG), .AW(AW), .WORD(WORD)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Register cell array reserve bits, driven by the controller's strobes.
  logic [31:0] cells;
  logic        use_tbl;
  logic [31:0] tbl_rsv;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cells <= 32'd0;
    else      cells <= ((cells & ~bus.rf_unreserve) | bus.rf_reserve) & ~32'd1;
  end
  assign bus.rf_reserved = use_tbl ? tbl_rsv : cells;

  int n_chk;
  int n_pass;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic iss(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                     input logic [4:0] rd, input logic we);
    bus.iss_valid = v; bus.iss_rs1 = r1; bus.iss_rs2 = r2; bus.iss_rd = rd; bus.iss_rd_we = we;
  endtask

  task automatic wb(input int unit, input logic v, input logic [4:0] rd, input logic [31:0] d);
    if (unit == 0) begin bus.wb0_valid = v; bus.wb0_rd = rd; bus.wb0_data = d; end
    else           begin bus.wb1_valid = v; bus.wb1_rd = rd; bus.wb1_data = d; end
  endtask

  task automatic set_idle();
    iss(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    wb(0, 1'b0, 5'd0, 32'd0);
    wb(1, 1'b0, 5'd0, 32'd0);
    bus.flush = 1'b0;
  endtask

  task automatic do_reset();
    set_idle();
    @(negedge clk) rst = 1'b0;
    @(negedge clk) rst = 1'b1;
    step();
  endtask

  typedef struct {
    logic iv; logic [4:0] rs1, rs2, rd; logic we;
    logic w0v; logic [4:0] w0rd; logic w1v; logic [4:0] w1rd;
    logic [31:0] rsv;
    logic e_ir, e_r0, e_r1; logic [31:0] e_res, e_wb, e_wd;
  } vec_t;
  vec_t tv[11];

  // Behavioural model state: mode 0=run 1=drain 2=done, prio = unit with priority.
  int m_mode, m_prio, m_cnt;

  function automatic bit held(int i);
    return (i != 0) && (cells[i] == 1'b1);
  endfunction

  function automatic logic [4:0] pick_rd();
    int q[$];
    for (int i = 1; i < NREG; i++) if (cells[i]) q.push_back(i);
    if (q.size() > 0 && ($urandom % 4) != 0) return 5'(q[$urandom % q.size()]);
    return 5'($urandom_range(0, 7));
  endfunction

  initial begin
    n_chk = 0; n_pass = 0; use_tbl = 1'b0; tbl_rsv = 32'd0;
    set_idle();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #4;
    chk("rst_outstanding", bus.outstanding, 0);
    chk("rst_flush_done", bus.flush_done, 0);
    chk("rst_iss_ready", bus.iss_ready, 1);
    chk("rst_rf_wb", bus.rf_wb, 0);
    chk("rst_rf_wdata", bus.rf_wdata, 0);
    @(negedge clk) rst = 1'b1;
    step();

    // ---- vector table (one clean cycle each, cell bits forced) ----
    tv[0]  = '{1'b1, 5'd1, 5'd2, 5'd5,  1'b1, 1'b0, 5'd0,  1'b0, 5'd0,  32'd0,
               1'b1, 1'b0, 1'b0, 32'd1 << 5,  32'd0, 32'd0};
    tv[1]  = '{1'b1, 5'd5, 5'd2, 5'd6,  1'b1, 1'b0, 5'd0,  1'b0, 5'd0,  32'd1 << 5,
               1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0};
    tv[2]  = '{1'b1, 5'd1, 5'd9, 5'd6,  1'b1, 1'b0, 5'd0,  1'b0, 5'd0,  32'd1 << 9,
               1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0};
    tv[3]  = '{1'b1, 5'd1, 5'd2, 5'd9,  1'b1, 1'b0, 5'd0,  1'b0, 5'd0,  32'd1 << 9,
               1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0};
    tv[4]  = '{1'b1, 5'd1, 5'd2, 5'd9,  1'b0, 1'b0, 5'd0,  1'b0, 5'd0,  32'd1 << 9,
               1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0};
    tv[5]  = '{1'b1, 5'd0, 5'd0, 5'd0,  1'b1, 1'b0, 5'd0,  1'b0, 5'd0,  32'd1,
               1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0};
    tv[6]  = '{1'b0, 5'd1, 5'd2, 5'd3,  1'b1, 1'b0, 5'd0,  1'b0, 5'd0,  32'd0,
               1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0};
    tv[7]  = '{1'b0, 5'd0, 5'd0, 5'd0,  1'b0, 1'b1, 5'd5,  1'b0, 5'd0,  32'd1 << 5,
               1'b1, 1'b1, 1'b0, 32'd0, 32'd1 << 5, D0};
    tv[8]  = '{1'b0, 5'd0, 5'd0, 5'd0,  1'b0, 1'b0, 5'd0,  1'b1, 5'd31, 32'd1 << 31,
               1'b1, 1'b0, 1'b1, 32'd0, 32'd1 << 31, D1};
    tv[9]  = '{1'b1, 5'd1, 5'd2, 5'd10, 1'b1, 1'b0, 5'd0,  1'b1, 5'd10, 32'd0,
               1'b1, 1'b0, 1'b1, 32'd1 << 10, 32'd1 << 10, D1};
    tv[10] = '{1'b1, 5'd3, 5'd4, 5'd12, 1'b1, 1'b1, 5'd12, 1'b0, 5'd0,  32'd1 << 12,
               1'b0, 1'b1, 1'b0, 32'd0, 32'd1 << 12, D0};
    use_tbl = 1'b1;
    for (int i = 0; i < 11; i++) begin
      iss(tv[i].iv, tv[i].rs1, tv[i].rs2, tv[i].rd, tv[i].we);
      wb(0, tv[i].w0v, tv[i].w0rd, D0);
      wb(1, tv[i].w1v, tv[i].w1rd, D1);
      tbl_rsv = tv[i].rsv;
      #3;
      chk($sformatf("tv%0d_iss_ready", i), bus.iss_ready, tv[i].e_ir);
      chk($sformatf("tv%0d_wb0_ready", i), bus.wb0_ready, tv[i].e_r0);
      chk($sformatf("tv%0d_wb1_ready", i), bus.wb1_ready, tv[i].e_r1);
      chk($sformatf("tv%0d_reserve", i), bus.rf_reserve, tv[i].e_res);
      chk($sformatf("tv%0d_rf_wb", i), bus.rf_wb, tv[i].e_wb);
      chk($sformatf("tv%0d_unreserve", i), bus.rf_unreserve, tv[i].e_wb);
      chk($sformatf("tv%0d_wdata", i), bus.rf_wdata, tv[i].e_wd);
      step();
    end
    use_tbl = 1'b0;
    do_reset();

    // ---- issue, reserve, RAW stall, writeback release ----
    iss(1'b1, 5'd1, 5'd2, 5'd5, 1'b1); #3;
    chk("s1_ready", bus.iss_ready, 1);
    chk("s1_reserve", bus.rf_reserve, 32'd1 << 5);
    step();
    iss(1'b1, 5'd5, 5'd2, 5'd6, 1'b1); #3;
    chk("s1_outstanding", bus.outstanding, 1);
    chk("s1_raw_stall", bus.iss_ready, 0);
    step();
    wb(0, 1'b1, 5'd5, 32'hDEADBEEF); #3;
    chk("s2_wb0_ready", bus.wb0_ready, 1);
    chk("s2_rf_wb", bus.rf_wb, 32'd1 << 5);
    chk("s2_unreserve", bus.rf_unreserve, 32'd1 << 5);
    chk("s2_wdata", bus.rf_wdata, 32'hDEADBEEF);
    chk("s2_no_bypass", bus.iss_ready, 0);
    step();
    wb(0, 1'b0, 5'd0, 32'd0); #3;
    chk("s2_dep_ready", bus.iss_ready, 1);
    chk("s2_outstanding", bus.outstanding, 0);
    step();
    iss(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    wb(1, 1'b1, 5'd6, 32'h1111_2222); #3;
    chk("s2_wb1_ready", bus.wb1_ready, 1);
    step();
    wb(1, 1'b0, 5'd0, 32'd0);

    // ---- round-robin alternation with both units valid ----
    iss(1'b1, 5'd1, 5'd2, 5'd3, 1'b1); step();
    iss(1'b1, 5'd1, 5'd2, 5'd4, 1'b1); step();
    iss(1'b0, 5'd0, 5'd0, 5'd0, 1'b0); #3;
    chk("s3_outstanding2", bus.outstanding, 2);
    for (int k = 0; k < 4; k++) begin
      wb(0, 1'b1, 5'd3, D0); wb(1, 1'b1, 5'd4, D1); #3;
      chk($sformatf("s3_g0_c%0d", k), bus.wb0_ready, (k % 2) == 0);
      chk($sformatf("s3_g1_c%0d", k), bus.wb1_ready, (k % 2) == 1);
      chk($sformatf("s3_wd_c%0d", k), bus.rf_wdata, ((k % 2) == 0) ? D0 : D1);
      step();
    end
    set_idle(); #3;
    chk("s3_outstanding0", bus.outstanding, 0);

    // ---- zero register on issue and writeback ----
    iss(1'b1, 5'd0, 5'd0, 5'd0, 1'b1); wb(0, 1'b1, 5'd0, D0); #3;
    chk("s4_iss_ready", bus.iss_ready, 1);
    chk("s4_reserve", bus.rf_reserve, 0);
    chk("s4_rf_wb", bus.rf_wb, 0);
    chk("s4_unreserve", bus.rf_unreserve, 0);
    chk("s4_wb0_ready", bus.wb0_ready, 1);
    step(); set_idle(); #3;
    chk("s4_outstanding", bus.outstanding, 0);

    // ---- flush drain with two outstanding ----
    iss(1'b1, 5'd1, 5'd2, 5'd7, 1'b1); step();
    iss(1'b1, 5'd1, 5'd2, 5'd8, 1'b1); step();
    iss(1'b0, 5'd0, 5'd0, 5'd0, 1'b0); bus.flush = 1'b1; step();
    bus.flush = 1'b0; iss(1'b1, 5'd1, 5'd2, 5'd9, 1'b1); wb(0, 1'b1, 5'd7, D0); #3;
    chk("s5_drain_stall", bus.iss_ready, 0);
    chk("s5_outstanding2", bus.outstanding, 2);
    chk("s5_wb_in_drain", bus.wb0_ready, 1);
    chk("s5_no_done", bus.flush_done, 0);
    step();
    wb(0, 1'b0, 5'd0, 32'd0); wb(1, 1'b1, 5'd8, D1); #3;
    chk("s5_wb1_ready", bus.wb1_ready, 1);
    step();
    wb(1, 1'b0, 5'd0, 32'd0); #3;
    chk("s5_outstanding0", bus.outstanding, 0);
    chk("s5_done_not_yet", bus.flush_done, 0);
    chk("s5_still_drain", bus.iss_ready, 0);
    step(); #3;
    chk("s5_done_pulse", bus.flush_done, 1);
    chk("s5_done_stall", bus.iss_ready, 0);
    step(); #3;
    chk("s5_done_cleared", bus.flush_done, 0);
    chk("s5_resume", bus.iss_ready, 1);
    chk("s5_resume_res", bus.rf_reserve, 32'd1 << 9);
    step();
    iss(1'b0, 5'd0, 5'd0, 5'd0, 1'b0); wb(0, 1'b1, 5'd9, D0); step();
    wb(0, 1'b0, 5'd0, 32'd0); bus.flush = 1'b1; step();
    bus.flush = 1'b0; #3;
    chk("s5e_drain_one", bus.iss_ready, 0);
    chk("s5e_no_done", bus.flush_done, 0);
    step(); #3;
    chk("s5e_done", bus.flush_done, 1);
    step(); #3;
    chk("s5e_run", bus.iss_ready, 1);
    chk("s5e_done_clr", bus.flush_done, 0);

    // ---- async reset during drain ----
    iss(1'b1, 5'd1, 5'd2, 5'd11, 1'b1); step();
    iss(1'b1, 5'd1, 5'd2, 5'd12, 1'b1); step();
    iss(1'b0, 5'd0, 5'd0, 5'd0, 1'b0); bus.flush = 1'b1; step();
    bus.flush = 1'b0; wb(0, 1'b1, 5'd20, D0); step();
    set_idle(); #1;
    chk("s6_pre_outstanding", bus.outstanding, 2);
    chk("s6_pre_drain", bus.iss_ready, 0);
    #1 rst = 1'b0; #1;
    chk("s6_outstanding", bus.outstanding, 0);
    chk("s6_run", bus.iss_ready, 1);
    chk("s6_flush_done", bus.flush_done, 0);
    @(negedge clk) rst = 1'b1;
    step();
    wb(0, 1'b1, 5'd21, D0); wb(1, 1'b1, 5'd22, D1); #3;
    chk("s6_rr_wb0", bus.wb0_ready, 1);
    chk("s6_rr_wb1", bus.wb1_ready, 0);
    step();
    do_reset();

    // ---- random traffic against the behavioural model ----
    m_mode = 0; m_prio = 0; m_cnt = 0;
    for (int c = 0; c < 500; c++) begin
      logic iv, we, w0v, w1v, fl, g0, g1, ir;
      logic [4:0] r1, r2, rd, w0rd, w1rd, grd;
      logic [31:0] w0d, w1d, e_res, e_wb, e_wd;
      int inc, dec;
      iv = 1'($urandom % 2); we = 1'(($urandom % 3) != 0);
      r1 = 5'($urandom_range(0, 7)); r2 = 5'($urandom_range(0, 7)); rd = 5'($urandom_range(0, 7));
      w0v = 1'($urandom % 2); w0rd = pick_rd(); w0d = $urandom;
      w1v = 1'($urandom % 2); w1rd = pick_rd(); w1d = $urandom;
      fl = 1'(($urandom % 25) == 0);
      iss(iv, r1, r2, rd, we); wb(0, w0v, w0rd, w0d); wb(1, w1v, w1rd, w1d); bus.flush = fl;
      #3;
      ir = (m_mode == 0) && !held(r1) && !held(r2) && !(we && held(rd));
      g0 = w0v && (!w1v || m_prio == 0);
      g1 = w1v && (!w0v || m_prio == 1);
      grd = g0 ? w0rd : w1rd;
      e_res = (iv && ir && we && rd != 5'd0) ? (32'd1 << rd) : 32'd0;
      e_wb  = ((g0 || g1) && grd != 5'd0) ? (32'd1 << grd) : 32'd0;
      e_wd  = g0 ? w0d : (g1 ? w1d : 32'd0);
      chk("rnd_iss_ready", bus.iss_ready, ir);
      chk("rnd_wb0_ready", bus.wb0_ready, g0);
      chk("rnd_wb1_ready", bus.wb1_ready, g1);
      chk("rnd_reserve", bus.rf_reserve, e_res);
      chk("rnd_rf_wb", bus.rf_wb, e_wb);
      chk("rnd_unreserve", bus.rf_unreserve, e_wb);
      if (!((g0 || g1) && grd == 5'd0)) chk("rnd_wdata", bus.rf_wdata, e_wd);
      chk("rnd_flush_done", bus.flush_done, m_mode == 2);
      chk("rnd_outstanding", bus.outstanding, m_cnt);
      inc = (e_res != 32'd0) ? 1 : 0;
      dec = (e_wb != 32'd0 && held(grd)) ? 1 : 0;
      case (m_mode)
        0: m_mode = fl ? 1 : 0;
        1: m_mode = (m_cnt == 0) ? 2 : 1;
        default: m_mode = 0;
      endcase
      m_cnt = m_cnt + inc - dec;
      if (m_cnt < 0) m_cnt = 0;
      if (m_cnt > NREG - 1) m_cnt = NREG - 1;
      if (g0) m_prio = 1;
      else if (g1) m_prio = 0;
      step();
    end
    set_idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
